// File: rtl/fpu_pkg.sv
// Shared FPU controller widths, default latencies and tag type.
package fpu_pkg;

  localparam int FDIV_LATENCY = 10;
  localparam int FP_W         = 32;
  localparam int FDIV_TAG_W   = 6;

  typedef logic [FDIV_TAG_W-1:0] fdiv_tag_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous first-word-fall-through result FIFO supporting any depth >= 1.
// Latency: a pushed word appears at dout the cycle after the push edge.
// Backpressure: push is legal only when !full or popping in the same cycle; overflow fires an assertion.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int WIDTH = FP_W + FDIV_TAG_W,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full && !pop));
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fdiv_issue_ctrl.sv
// Issues divides into fdiv, carries tags in a latency-matched pipe and buffers results for writeback.
// Latency: result visible on wb_* LATENCY+1 cycles after the issue edge.
// Backpressure: credit counter caps pipe+FIFO occupancy at OUT_DEPTH; req_ready has no path from wb_ready.
module fdiv_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LATENCY   = FDIV_LATENCY,
  parameter int TAG_W     = FDIV_TAG_W,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FP_W-1:0]  req_x1,
  input  logic [FP_W-1:0]  req_x2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [FP_W-1:0]  div_x1,
  output logic [FP_W-1:0]  div_x2,
  input  logic [FP_W-1:0]  div_y,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [FP_W-1:0]  wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int EW = FP_W + TAG_W;

  logic [LATENCY-1:0] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      fifo_count;
  logic [EW-1:0]      fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fire;
  logic               pop;

  assign req_ready         = (outstanding < CW'(OUT_DEPTH)) & ~flush;
  assign fire              = req_valid & req_ready;
  assign div_x1            = req_x1;
  assign div_x2            = req_x2;
  assign wb_valid          = ~fifo_empty;
  assign pop               = wb_valid & wb_ready;
  assign {wb_tag, wb_data} = fifo_dout;
  assign busy              = (outstanding != '0);

  // Credit is charged at issue and only returned at writeback, so capture never overflows.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pipe_vld    <= '0;
      outstanding <= '0;
    end else begin
      assert (outstanding >= fifo_count);
      assert (!(pipe_vld[LATENCY-1] && fifo_full && !pop));
      pipe_vld[0] <= fire;
      for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      case ({fire, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Tags need no reset; they are qualified by pipe_vld.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= req_tag;
    for (int i = 1; i < LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  fpu_result_fifo #(
    .WIDTH (EW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (pipe_vld[LATENCY-1]),
    .din   ({pipe_tag[LATENCY-1], div_y}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Scoreboard bench for fdiv_issue_ctrl with a fixed-latency behavioural fdiv.
module tb_fdiv_issue_ctrl;
  import fpu_pkg::*;

  localparam int LAT = 10;
  localparam int TW  = FDIV_TAG_W;

  typedef struct packed {
    fdiv_tag_t   tag;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x1;
  logic [31:0] req_x2;
  fdiv_tag_t   req_tag;
  logic        flush;
  logic [31:0] div_x1;
  logic [31:0] div_x2;
  logic [31:0] div_y;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  fdiv_tag_t   wb_tag;
  logic        busy;

  logic [31:0] vx1 [6] = '{32'h40C00000, 32'h3F800000, 32'h41100000, 32'h41200000, 32'h41000000, 32'hC0C00000};
  logic [31:0] vx2 [6] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40000000, 32'h40000000};
  logic [31:0] vq  [6] = '{32'h40400000, 32'h3F000000, 32'h40400000, 32'h40200000, 32'h40800000, 32'hC0400000};

  logic [31:0] fdiv_stage [LAT];
  exp_t        sb [$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  bit          acc;
  int          n_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fdiv_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW), .OUT_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_tag   (req_tag),
    .flush     (flush),
    .div_x1    (div_x1),
    .div_x2    (div_x2),
    .div_y     (div_y),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_tag    (wb_tag),
    .busy      (busy)
  );

  // Behavioural fdiv: known quotients for the directed operands, quiet NaN otherwise.
  function automatic logic [31:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40000000}: return 32'h3F000000;
      {32'h41100000, 32'h40400000}: return 32'h40400000;
      {32'h41200000, 32'h40800000}: return 32'h40200000;
      {32'h41000000, 32'h40000000}: return 32'h40800000;
      {32'hC0C00000, 32'h40000000}: return 32'hC0400000;
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  always @(posedge clk) begin
    fdiv_stage[0] <= fdiv_ref(div_x1, div_x2);
    for (int i = 1; i < LAT; i++) fdiv_stage[i] <= fdiv_stage[i-1];
  end
  assign div_y = fdiv_stage[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic offer(input int v, input fdiv_tag_t tag, output bit accepted);
    req_valid = 1'b1;
    req_x1    = vx1[v];
    req_x2    = vx2[v];
    req_tag   = tag;
    settle();
    accepted = req_ready;
    if (accepted) sb.push_back('{tag: tag, data: vq[v]});
  endtask

  task automatic idle();
    req_valid = 1'b0;
    wb_ready  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!busy && sb.size() == 0) break;
      tick();
    end
    settle();
    chk("drain_busy", busy, 0);
    chk("drain_scoreboard", sb.size(), 0);
  endtask

  // Monitor: every accepted writeback must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got tag %h data %h, expected no result (cycle %0d)", wb_tag, wb_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_data", wb_data, mon_e.data);
        chk("wb_tag", wb_tag, mon_e.tag);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_x1 = '0; req_x2 = '0; req_tag = '0;
    flush = 1'b0; wb_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    settle();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_tag", wb_tag, 0);

    // Single op: 6.0 / 2.0, tag 5, fired in cycle 0.
    wb_ready = 1'b1;
    tick();
    offer(0, TW'(5), acc);
    chk("t1_accept", acc, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) req_valid = 1'b0;
      settle();
      if (k >= 10) begin
        chk("t1_wb_valid", wb_valid, k == 11);
        chk("t1_busy", busy, k < 12);
      end
    end
    idle();

    // Back-to-back: tags 1-4 in cycles 0-3, results in cycles 11-14.
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      offer(k + 1, TW'(k + 1), acc);
      chk("t2_req_ready", acc, 1);
    end
    for (int k = 4; k <= 15; k++) begin
      tick();
      if (k == 4) req_valid = 1'b0;
      settle();
      if (k >= 10) chk("t2_wb_valid", wb_valid, (k >= 11) && (k <= 14));
    end
    idle();

    // Back-pressure: 6 offered with wb_ready low, exactly 4 accepted.
    wb_ready = 1'b0;
    n_acc = 0;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      offer(k, TW'(10 + k), acc);
      chk("t3_req_ready", acc, k < 4);
      if (acc) n_acc++;
    end
    chk("t3_accepted", n_acc, 4);
    for (int k = 6; k <= 20; k++) begin
      tick();
      if (k == 6) req_valid = 1'b0;
    end
    settle();
    chk("t3_full_req_ready", req_ready, 0);
    chk("t3_full_wb_valid", wb_valid, 1);
    tick();
    wb_ready = 1'b1;
    settle();
    chk("t3_pop_cycle_req_ready", req_ready, 0);
    tick();
    settle();
    chk("t3_after_pop_req_ready", req_ready, 1);
    idle();

    // Fire and pop together at outstanding=3: credit must stay at 3.
    wb_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      offer(k, TW'(20 + k), acc);
      chk("t4_fill_accept", acc, 1);
    end
    for (int k = 3; k <= 14; k++) begin
      tick();
      if (k == 3) req_valid = 1'b0;
    end
    wb_ready = 1'b1;
    offer(3, TW'(23), acc);
    chk("t4_fire_with_pop", acc, 1);
    chk("t4_wb_valid", wb_valid, 1);
    tick();
    wb_ready = 1'b0;
    offer(4, TW'(24), acc);
    chk("t4_one_credit_left", acc, 1);
    tick();
    offer(5, TW'(25), acc);
    chk("t4_no_credit_left", acc, 0);
    tick();
    idle();

    // Flush at cycle 5 with 3 ops in flight; new op in cycle 6 returns in cycle 17.
    wb_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      offer(k, TW'(30 + k), acc);
      chk("t5_fill_accept", acc, 1);
    end
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    offer(0, TW'(33), acc);
    chk("t5_flush_blocks_req", acc, 0);
    sb.delete();
    tick();
    flush = 1'b0;
    offer(1, TW'(34), acc);
    chk("t5_post_flush_accept", acc, 1);
    chk("t5_wb_valid_after_flush", wb_valid, 0);
    for (int k = 7; k <= 17; k++) begin
      tick();
      if (k == 7) req_valid = 1'b0;
      settle();
      if (((k >= 11) && (k <= 13)) || (k >= 16)) chk("t5_wb_valid", wb_valid, k == 17);
    end
    idle();

    // Reset in cycle 7 with ops in flight: outputs at reset values in cycle 8, no stale result.
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      offer(k, TW'(40 + k), acc);
      chk("t6_fill_accept", acc, 1);
    end
    for (int k = 3; k <= 7; k++) begin
      tick();
      if (k == 3) req_valid = 1'b0;
    end
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    settle();
    chk("t6_req_ready", req_ready, 1);
    chk("t6_wb_valid", wb_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_wb_data", wb_data, 0);
    chk("t6_wb_tag", wb_tag, 0);
    for (int k = 9; k <= 15; k++) begin
      tick();
      settle();
      if (k >= 10) chk("t6_no_stale_wb", wb_valid, 0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
